// File: rtl/bcd_disp_pkg.sv
// Shared constants and types for the BCD scan display.
// Optional build macro used by this block: LEADING_ZERO_BLANK_EN.
package bcd_disp_pkg;

  localparam int unsigned SEG_W   = 7;
  localparam int unsigned DIGIT_W = 4;
  localparam int unsigned AN_W    = 3;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;
  localparam logic [SEG_W-1:0] SEG_DASH  = 7'h3F;
  localparam logic [SEG_W-1:0] SEG_DIGIT [0:9] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
    7'h12, 7'h02, 7'h78, 7'h00, 7'h10
  };

  // Active-low anode codes, bit order {hundreds,tens,ones}
  localparam logic [AN_W-1:0] AN_OFF      = 3'b111;
  localparam logic [AN_W-1:0] AN_ONES     = 3'b110;
  localparam logic [AN_W-1:0] AN_TENS     = 3'b101;
  localparam logic [AN_W-1:0] AN_HUNDREDS = 3'b011;

  typedef enum logic [1:0] {
    DIG_ONES     = 2'd0,
    DIG_TENS     = 2'd1,
    DIG_HUNDREDS = 2'd2
  } dig_state_e;

  typedef struct packed {
    logic [DIGIT_W-1:0] hundreds;
    logic [DIGIT_W-1:0] tens;
    logic [DIGIT_W-1:0] ones;
  } bcd_snap_t;

  // A digit counts as zero only when it is a literal 0 nibble
  function automatic logic is_zero_digit(input logic [DIGIT_W-1:0] d);
    return (d == 4'd0);
  endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD nibble to active-low 7-segment decoder; invalid BCD shows a dash.
module bcd_to_seg7
  import bcd_disp_pkg::*;
(
  input  logic [DIGIT_W-1:0] bcd_i,
  output logic [SEG_W-1:0]   seg_o_c
);

  // Decode one nibble; values 10..15 fall through to the dash pattern
  always_comb begin
    seg_o_c = SEG_DASH;
    case (bcd_i)
      4'd0:    seg_o_c = SEG_DIGIT[0];
      4'd1:    seg_o_c = SEG_DIGIT[1];
      4'd2:    seg_o_c = SEG_DIGIT[2];
      4'd3:    seg_o_c = SEG_DIGIT[3];
      4'd4:    seg_o_c = SEG_DIGIT[4];
      4'd5:    seg_o_c = SEG_DIGIT[5];
      4'd6:    seg_o_c = SEG_DIGIT[6];
      4'd7:    seg_o_c = SEG_DIGIT[7];
      4'd8:    seg_o_c = SEG_DIGIT[8];
      4'd9:    seg_o_c = SEG_DIGIT[9];
      default: seg_o_c = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_scan_display.sv
// Snapshots a 3-digit BCD value and scans it onto a common-anode 7-segment bus.
// Optional build macro: LEADING_ZERO_BLANK_EN (blank leading zeros of hundreds/tens).
module bcd_scan_display
  import bcd_disp_pkg::*;
#(
  parameter int unsigned REFRESH_DIV  = 50000,
  parameter int unsigned BLANK_CYCLES = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [DIGIT_W-1:0] onesplace,
  input  logic [DIGIT_W-1:0] tensplace,
  input  logic [DIGIT_W-1:0] hundredsplace,
  output logic [SEG_W-1:0]   seg,
  output logic [AN_W-1:0]    an,
  output logic               frame_done
);

  localparam int unsigned      CNT_W     = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);

  bcd_snap_t          snap_q, snap_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  dig_state_e         state_q, state_d;
  logic [SEG_W-1:0]   seg_q, seg_d;
  logic [AN_W-1:0]    an_q, an_d;
  logic               fd_q, fd_d;

  logic               slot_end_c;
  logic               state_valid_c;
  logic [DIGIT_W-1:0] dig_sel_c;
  logic [AN_W-1:0]    an_sel_c;
  logic               lz_blank_c;
  logic [SEG_W-1:0]   dig_seg_c;

  // Snapshot capture: tracks inputs whenever load is high, otherwise holds
  always_comb begin
    snap_d = snap_q;
    if (load) begin
      snap_d = '{hundreds: hundredsplace, tens: tensplace, ones: onesplace};
    end
  end

  // Slot counter and digit FSM next-state, plus the end-of-frame pulse
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + CNT_W'(1);
    slot_end_c = (cnt_q >= CNT_LAST);
    fd_d       = 1'b0;
    if (slot_end_c) begin
      cnt_d = '0;
    end
    case (state_q)
      DIG_ONES: begin
        if (slot_end_c) state_d = DIG_TENS;
      end
      DIG_TENS: begin
        if (slot_end_c) state_d = DIG_HUNDREDS;
      end
      DIG_HUNDREDS: begin
        if (slot_end_c) begin
          state_d = DIG_ONES;
          fd_d    = 1'b1;
        end
      end
      default: begin
        state_d = DIG_ONES;
        cnt_d   = '0;
      end
    endcase
  end

  // Select the digit and anode for the current slot, and its leading-zero blank
  always_comb begin
    dig_sel_c     = snap_q.ones;
    an_sel_c      = AN_OFF;
    state_valid_c = 1'b1;
    lz_blank_c    = 1'b0;
    case (state_q)
      DIG_ONES: begin
        dig_sel_c = snap_q.ones;
        an_sel_c  = AN_ONES;
      end
      DIG_TENS: begin
        dig_sel_c = snap_q.tens;
        an_sel_c  = AN_TENS;
`ifdef LEADING_ZERO_BLANK_EN
        lz_blank_c = is_zero_digit(snap_q.hundreds) && is_zero_digit(snap_q.tens);
`endif
      end
      DIG_HUNDREDS: begin
        dig_sel_c = snap_q.hundreds;
        an_sel_c  = AN_HUNDREDS;
`ifdef LEADING_ZERO_BLANK_EN
        lz_blank_c = is_zero_digit(snap_q.hundreds);
`endif
      end
      default: begin
        state_valid_c = 1'b0;
      end
    endcase
  end

  bcd_to_seg7 u_dec (
    .bcd_i   (dig_sel_c),
    .seg_o_c (dig_seg_c)
  );

  // Output pipeline: blank window at slot start keeps anode changes dark
  always_comb begin
    seg_d = SEG_BLANK;
    an_d  = AN_OFF;
    if (state_valid_c && (cnt_q >= CNT_BLANK)) begin
      an_d  = an_sel_c;
      seg_d = lz_blank_c ? SEG_BLANK : dig_seg_c;
    end
  end

  // State, snapshot and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      snap_q  <= '0;
      cnt_q   <= '0;
      state_q <= DIG_ONES;
      seg_q   <= SEG_BLANK;
      an_q    <= AN_OFF;
      fd_q    <= 1'b0;
    end else begin
      snap_q  <= snap_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
      fd_q    <= fd_d;
    end
  end

  assign seg        = seg_q;
  assign an         = an_q;
  assign frame_done = fd_q;

endmodule
